// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: default geometry, NOP word and boot program image for the instruction memory.
package instr_mem_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam logic [DATA_W_DEF-1:0] NOP_WORD_DEF = '0;
  function automatic logic [15:0] image_word(int i);
    case (i)
      1: return 16'h8002;
      2: return 16'h4400;
      3: return 16'h8003;
      4: return 16'h4800;
      5: return 16'h8401;
      6: return 16'h4000;
      7: return 16'h8003;
      8: return 16'h4800;
      default: return 16'h0000;
    endcase
  endfunction
endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: program storage with combinational read; a writable array with
// write-first bypass when IMEM_LOAD_EN is defined, otherwise a constant ROM.
module instr_mem_array import instr_mem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
`ifdef IMEM_LOAD_EN
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  // One register per word keeps the boot image as a plain declaration initialiser.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
`ifdef IMEM_LOAD_EN
    logic [DATA_W-1:0] word_q = DATA_W'(image_word(i));
    always_ff @(posedge clk) if (wr_en && wr_addr == ADDR_W'(i)) word_q <= wr_data;
    assign mem[i] = word_q;
`else
    assign mem[i] = DATA_W'(image_word(i));
`endif
  end
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < DEPTH; k++) rd_data = (rd_addr == ADDR_W'(k)) ? mem[k] : rd_data;
`ifdef IMEM_LOAD_EN
    rd_data = (wr_en && wr_addr == rd_addr) ? wr_data : rd_data;
`endif
  end
endmodule

// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe: valid/ready instruction fetch with one registered response stage,
// out-of-range detection and saturating error count; IMEM_LOAD_EN adds a load port.
module instr_mem_pipe import instr_mem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef IMEM_LOAD_EN
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [7:0]        err_cnt
);
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, accept, oor;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d, rd_data;
  logic [7:0] err_cnt_q, err_cnt_d;
  instr_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
`ifdef IMEM_LOAD_EN
    .clk(clk),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
`endif
    .rd_addr(req_addr),
    .rd_data(rd_data)
  );
  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept = req_valid && req_ready;
  // Extra bit lets DEPTH = 2**ADDR_W compare without wrapping.
  assign oor = {1'b0, req_addr} >= (ADDR_W+1)'(DEPTH);
  always_comb begin
    rsp_valid_d = req_ready ? req_valid : rsp_valid_q;
    rsp_data_d = accept ? (oor ? NOP_WORD : rd_data) : rsp_data_q;
    rsp_err_d = accept ? oor : rsp_err_q;
    err_cnt_d = (accept && oor && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q <= NOP_WORD;
      rsp_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_instr_mem_pipe.sv
// tb_instr_mem_pipe: directed and random fetch traffic against a transaction-level
// model of the program image and the single response slot.
module tb_instr_mem_pipe;
  logic clk, rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [7:0] req_addr, err_cnt;
  logic [15:0] rsp_data;
`ifdef IMEM_LOAD_EN
  logic wr_en;
  logic [7:0] wr_addr;
  logic [15:0] wr_data;
`endif
  int n_checks, n_errors;
  logic [15:0] img [16];
  logic m_valid, m_err;
  logic [15:0] m_data;
  int m_cnt;

  instr_mem_pipe dut (
    .clk(clk),
    .rst(rst),
`ifdef IMEM_LOAD_EN
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input logic r);
    check("req_ready", 32'(req_ready), 32'(!m_valid || r));
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      check("rsp_data", 32'(rsp_data), 32'(m_data));
      check("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    check("err_cnt", 32'(err_cnt), 32'(m_cnt));
  endtask

  // Drive one cycle from a negedge, check, then advance the model at the posedge.
  task automatic cycle(input logic v, input logic [7:0] a, input logic r);
    req_valid = v;
    req_addr = a;
    rsp_ready = r;
    #1;
    check_outputs(r);
    @(posedge clk);
`ifdef IMEM_LOAD_EN
    if (wr_en && wr_addr < 16) img[wr_addr[3:0]] = wr_data;
`endif
    if (v && (!m_valid || r)) begin
      m_valid = 1'b1;
      m_err = a >= 16;
      m_data = (a < 16) ? img[a[3:0]] : 16'h0000;
      if (a >= 16 && m_cnt < 255) m_cnt++;
    end else if (r) m_valid = 1'b0;
    @(negedge clk);
`ifdef IMEM_LOAD_EN
    wr_en = 1'b0;
`endif
  endtask

  task automatic check_reset_state();
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", 32'(rsp_data), 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    img = '{16'h0000, 16'h8002, 16'h4400, 16'h8003, 16'h4800, 16'h8401, 16'h4000, 16'h8003,
            16'h4800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    m_valid = 1'b0; m_err = 1'b0; m_data = 16'h0; m_cnt = 0;
    n_checks = 0; n_errors = 0;
    rst = 1'b0; req_valid = 1'b0; req_addr = 8'h0; rsp_ready = 1'b1;
`ifdef IMEM_LOAD_EN
    wr_en = 1'b0; wr_addr = 8'h0; wr_data = 16'h0;
`endif
    repeat (2) @(negedge clk);
    check_reset_state();
    rst = 1'b1;
    cycle(1'b1, 8'd1, 1'b1);
    check("fetch1_valid", 32'(rsp_valid), 32'd1);
    check("fetch1_data", 32'(rsp_data), 32'h8002);
    cycle(1'b0, 8'd0, 1'b1);
    for (int i = 0; i <= 8; i++) cycle(1'b1, 8'(i), 1'b1);
    cycle(1'b0, 8'd0, 1'b1);
    cycle(1'b1, 8'd3, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'd7, 1'b0);
    check("stall_data", 32'(rsp_data), 32'h8003);
    cycle(1'b0, 8'd0, 1'b1);
    cycle(1'b0, 8'd0, 1'b1);
    cycle(1'b1, 8'd16, 1'b1);
    cycle(1'b1, 8'd200, 1'b1);
    cycle(1'b0, 8'd0, 1'b1);
    check("oor_cnt2", 32'(err_cnt), 32'd2);
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'(16 + (i % 240)), 1'b1);
    cycle(1'b0, 8'd0, 1'b1);
    check("err_sat", 32'(err_cnt), 32'd255);
`ifdef IMEM_LOAD_EN
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 16'hABCD;
    cycle(1'b1, 8'd5, 1'b1);
    check("bypass", 32'(rsp_data), 32'hABCD);
    wr_en = 1'b1; wr_addr = 8'd20; wr_data = 16'h1234;
    cycle(1'b1, 8'd4, 1'b1);
    check("oor_write_ignored", 32'(rsp_data), 32'h4800);
    cycle(1'b0, 8'd0, 1'b1);
`endif
    cycle(1'b1, 8'd6, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    m_valid = 1'b0; m_cnt = 0;
    check_reset_state();
    repeat (2) @(negedge clk);
    check_reset_state();
    rst = 1'b1;
    cycle(1'b1, 8'd2, 1'b1);
    check("post_rst_data", 32'(rsp_data), 32'h4400);
    for (int i = 0; i < 400; i++) begin
`ifdef IMEM_LOAD_EN
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = 8'($urandom_range(0, 19));
      wr_data = 16'($urandom);
`endif
      cycle(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17)),
            $urandom_range(0, 9) < 7);
    end
    cycle(1'b0, 8'd0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
